// File: rtl/rdl_reg_to_axil.sv
`default_nettype none
// ============================================================================
//  Module      : rdl_reg_to_axil
//  Description : AXI-Lite master bridge. Turns a single-outstanding register
//                request/response port into AXI-Lite read and write
//                transactions, with an optional B/R response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rdl_reg_to_axil #(
    parameter int AW            = 6,
    parameter int DW            = 8,
    parameter int TimeoutCycles = 0
) (
    input  logic            clk,
    input  logic            rst,
    // request / response port
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_wstrb,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            timeout,
    // AXI-Lite write address
    output logic            m_axil_awvalid,
    input  logic            m_axil_awready,
    output logic [AW-1:0]   m_axil_awaddr,
    // AXI-Lite write data
    output logic            m_axil_wvalid,
    input  logic            m_axil_wready,
    output logic [DW-1:0]   m_axil_wdata,
    output logic [DW/8-1:0] m_axil_wstrb,
    // AXI-Lite write response
    input  logic            m_axil_bvalid,
    output logic            m_axil_bready,
    input  logic [1:0]      m_axil_bresp,
    // AXI-Lite read address
    output logic            m_axil_arvalid,
    input  logic            m_axil_arready,
    output logic [AW-1:0]   m_axil_araddr,
    // AXI-Lite read data
    input  logic            m_axil_rvalid,
    output logic            m_axil_rready,
    input  logic [DW-1:0]   m_axil_rdata,
    input  logic [1:0]      m_axil_rresp
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            ar_done_q, ar_done_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            timeout_q, timeout_d;

    logic            accept;
    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            ar_hs;
    logic            r_hs;
    logic            expire;

    assign accept = req_valid && (state_q == S_IDLE);
    assign aw_hs  = awvalid_q && m_axil_awready;
    assign w_hs   = wvalid_q  && m_axil_wready;
    assign b_hs   = bready_q  && m_axil_bvalid;
    assign ar_hs  = arvalid_q && m_axil_arready;
    assign r_hs   = rready_q  && m_axil_rvalid;

    // Response timeout: only counts while waiting on B/R, since valid-side
    // phases cannot be withdrawn once raised.
    generate
        if (TimeoutCycles > 0) begin : g_timeout
            localparam int CW = $clog2(TimeoutCycles + 1);
            logic [CW-1:0] cnt_q, cnt_d;
            logic          waiting;

            assign waiting = (bready_q && !m_axil_bvalid) || (rready_q && !m_axil_rvalid);
            // A handshake in the last cycle takes priority because waiting is false then.
            assign expire  = waiting && (cnt_q == CW'(TimeoutCycles - 1));

            // Next counter value: cleared on accept, advanced while stalled on B/R.
            always_comb begin
                cnt_d = cnt_q;
                if (accept) begin
                    cnt_d = '0;
                end else if (waiting) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_done_d   = ar_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    if (req_write) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wvalid_d = 1'b0;
                end
                bready_d = aw_done_d && w_done_d;
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_err_d   = (m_axil_bresp != 2'b00);
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (expire) begin
                    bready_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    timeout_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_READ: begin
                if (ar_hs) begin
                    ar_done_d = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_err_d   = (m_axil_rresp != 2'b00);
                    rsp_rdata_d = m_axil_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (expire) begin
                    rready_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    timeout_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end

            default: begin
                // S_RESP: rsp_valid is high for this single cycle.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ar_done_q   <= ar_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign timeout        = timeout_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_rdl_reg_to_axil.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rdl_reg_to_axil
//  Description : Self-checking bench for rdl_reg_to_axil (TimeoutCycles=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rdl_reg_to_axil;

    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic [0:0] req_wstrb;
    logic       rsp_valid, rsp_err, timeout;
    logic [7:0] rsp_rdata;
    logic       awvalid, awready, wvalid, wready, bvalid, bready;
    logic       arvalid, arready, rvalid, rready;
    logic [5:0] awaddr, araddr;
    logic [7:0] wdata, rdata;
    logic [0:0] wstrb;
    logic [1:0] bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    rdl_reg_to_axil #(.AW(6), .DW(8), .TimeoutCycles(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .timeout(timeout),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_bresp(bresp),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready), .m_axil_araddr(araddr),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axil_rdata(rdata), .m_axil_rresp(rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [0:0] wstrb;
        int         aw_d;
        int         w_d;
        int         ar_d;
        int         resp_d;
        logic [1:0] resp;
        logic [7:0] rdata;
        int         exp_lat;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_to;
        int         exp_rr;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid  = 1'b0; rvalid = 1'b0;
        bresp   = 2'b00; rresp = 2'b00; rdata = 8'h00;
    endtask

    // Issue one request and act as the AXI slave with the vector's delays.
    task automatic run_vec(input vec_t v, input int idx);
        int   aw_hi = 0, w_hi = 0, ar_hi = 0, rdy_hi = 0;
        int   aw_b = 0, w_b = 0, ar_b = 0, rsp_n = 0, lat = -1, viol = 0, rwait = 0;
        logic aw_dn = 0, w_dn = 0, ar_dn = 0, r_dn = 0, ph_dn;
        logic [7:0] got_rdata = 8'h00;
        logic       got_err = 1'b0;
        string      tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_wstrb = ~v.wstrb;
        for (int k = 1; k <= 30; k++) begin
            clear_slave();
            bresp = v.resp; rresp = v.resp; rdata = v.rdata;
            if (awvalid) begin
                if (awaddr !== v.addr) viol++;
                if (aw_hi >= v.aw_d) begin awready = 1'b1; aw_b++; end
                aw_hi++;
            end
            if (wvalid) begin
                if (wdata !== v.wdata || wstrb !== v.wstrb) viol++;
                if (w_hi >= v.w_d) begin wready = 1'b1; w_b++; end
                w_hi++;
            end
            if (arvalid) begin
                if (araddr !== v.addr) viol++;
                if (ar_hi >= v.ar_d) begin arready = 1'b1; ar_b++; end
                ar_hi++;
            end
            if (bready || rready) rdy_hi++;
            if (bready && !(aw_dn && w_dn)) viol++;
            if (v.wr && (arvalid || rready)) viol++;
            if (!v.wr && (awvalid || wvalid || bready)) viol++;
            ph_dn = v.wr ? (aw_dn && w_dn) : ar_dn;
            if (ph_dn && !r_dn) begin
                if (rwait >= v.resp_d) begin
                    if (v.wr) bvalid = 1'b1; else rvalid = 1'b1;
                end
                rwait++;
            end
            if ((bvalid && bready) || (rvalid && rready)) r_dn = 1'b1;
            if (rsp_valid) begin
                rsp_n++;
                if (lat < 0) lat = k;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end
            if (awvalid && awready) aw_dn = 1'b1;
            if (wvalid && wready) w_dn = 1'b1;
            if (arvalid && arready) ar_dn = 1'b1;
            if (lat >= 0 && k >= lat + 2) break;
            @(posedge clk); #1;
        end
        clear_slave();
        chk({tag, "_rsp_count"}, rsp_n, 1);
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_rdata"}, {24'd0, got_rdata}, {24'd0, v.exp_rdata});
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, v.exp_to});
        chk({tag, "_aw_beats"}, aw_b, v.wr ? 1 : 0);
        chk({tag, "_w_beats"}, w_b, v.wr ? 1 : 0);
        chk({tag, "_ar_beats"}, ar_b, v.wr ? 0 : 1);
        chk({tag, "_aw_hi"}, aw_hi, v.wr ? v.aw_d + 1 : 0);
        chk({tag, "_w_hi"}, w_hi, v.wr ? v.w_d + 1 : 0);
        chk({tag, "_ar_hi"}, ar_hi, v.wr ? 0 : v.ar_d + 1);
        chk({tag, "_ready_hi"}, rdy_hi, v.exp_rr);
        chk({tag, "_protocol"}, viol, 0);
        chk({tag, "_idle_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int rsp1, rsp2, first_rdy, ar_first, rspn, overlap;
        logic [7:0] mem, r2data;

        // wr addr wdata strb aw w ar resp resp rdata lat exp_rdata err to rr
        vecs[0] = '{1'b1, 6'h14, 8'hA5, 1'b1, 0, 0, 0, 0,     2'b00, 8'h00, 3, 8'h00, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b1, 6'h20, 8'h5A, 1'b1, 3, 0, 0, 0,     2'b00, 8'h00, 6, 8'h00, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 6'h08, 8'h00, 1'b0, 0, 0, 2, 0,     2'b10, 8'h3C, 5, 8'h3C, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b1, 6'h3F, 8'hFF, 1'b1, 0, 2, 0, 1,     2'b11, 8'h00, 6, 8'h00, 1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 6'h00, 8'h00, 1'b0, 0, 0, 0, 0,     2'b00, 8'h81, 3, 8'h81, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 6'h2A, 8'h00, 1'b0, 0, 0, 0, 3,     2'b00, 8'hC3, 6, 8'hC3, 1'b0, 1'b0, 4};
        vecs[6] = '{1'b0, 6'h10, 8'h00, 1'b0, 0, 0, 0, NEVER, 2'b00, 8'hEE, 6, 8'h00, 1'b1, 1'b1, 4};
        vecs[7] = '{1'b1, 6'h04, 8'h11, 1'b1, 0, 0, 0, 0,     2'b00, 8'h00, 3, 8'h00, 1'b0, 1'b1, 1};
        vecs[8] = '{1'b0, 6'h05, 8'h00, 1'b0, 0, 0, 0, 0,     2'b00, 8'h99, 3, 8'h99, 1'b0, 1'b1, 1};

        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        clear_slave();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_addr", {26'd0, awaddr}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back write then read of the same address, req_valid held
        mem = 8'h00; r2data = 8'h00;
        rsp1 = -1; rsp2 = -1; first_rdy = -1; ar_first = -1; rspn = 0; overlap = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h2C; req_wdata = 8'h55; req_wstrb = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            awready = 1'b1; wready = 1'b1; arready = 1'b1;
            bvalid = 1'b1; bresp = 2'b00; rvalid = 1'b1; rresp = 2'b00; rdata = mem;
            if (awvalid && wvalid && awaddr == 6'h2C) mem = wdata;
            if (req_ready && first_rdy < 0) first_rdy = k;
            if (rsp_valid) begin
                rspn++;
                if (rsp1 < 0) begin
                    rsp1 = k;
                    req_write = 1'b0;
                end else begin
                    rsp2 = k;
                    r2data = rsp_rdata;
                end
            end
            if (arvalid && ar_first < 0) begin
                ar_first = k;
                req_valid = 1'b0;
            end
            if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap++;
            @(posedge clk); #1;
        end
        clear_slave();
        req_valid = 1'b0;
        chk("b2b_rsp1", rsp1, 3);
        chk("b2b_ready_again", first_rdy, 4);
        chk("b2b_ar_start", ar_first, 5);
        chk("b2b_rsp2", rsp2, 7);
        chk("b2b_rdata", {24'd0, r2data}, 32'h55);
        chk("b2b_rsp_count", rspn, 2);
        chk("b2b_overlap", overlap, 0);
        chk("b2b_timeout_sticky", {31'd0, timeout}, 32'd1);

        // Reset while WRITE is stalled with awvalid high
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h33; req_wdata = 8'h77; req_wstrb = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
        chk("mid_awaddr", {26'd0, awaddr}, 32'h33);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("mid_rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        rspn = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) rspn++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_rsp", rspn, 0);
        chk("mid_rst_idle", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
